// File: rtl/ex_stage.sv
// MIPS execute stage: combinational ALU for logic/shift/arith ops and a
// 32-step restoring divider for DIV/DIVU that stalls the pipeline until HI/LO is ready.
module ex_stage #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ALUSEL_W = 3,
    parameter int ALUOP_W  = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic [DATA_W-1:0]   reg_rd_data1_in,
    input  logic [DATA_W-1:0]   reg_rd_data2_in,
    input  logic [ADDR_W-1:0]   reg_wr_addr_in,
    input  logic                reg_wr_en_in,
    input  logic [ALUSEL_W-1:0] alusel_in,
    input  logic [ALUOP_W-1:0]  aluop_in,
    output logic [ADDR_W-1:0]   reg_wr_addr_out,
    output logic                reg_wr_en_out,
    output logic [DATA_W-1:0]   reg_wr_data_out,
    output logic                hilo_wr_en_out,
    output logic [DATA_W-1:0]   hi_out,
    output logic [DATA_W-1:0]   lo_out,
    output logic                ovf_exc_out,
    output logic                stall_req_out
);
    localparam int SH_W  = $clog2(DATA_W);
    localparam int CNT_W = $clog2(DATA_W);
    localparam int MSB   = DATA_W - 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DATA_W - 1);

    localparam logic [ALUSEL_W-1:0] SEL_LOGIC = ALUSEL_W'(1);
    localparam logic [ALUSEL_W-1:0] SEL_SHIFT = ALUSEL_W'(2);
    localparam logic [ALUSEL_W-1:0] SEL_ARITH = ALUSEL_W'(4);
    localparam logic [ALUSEL_W-1:0] SEL_DIV   = ALUSEL_W'(5);

    localparam logic [ALUOP_W-1:0] OP_AND  = ALUOP_W'(8'h24);
    localparam logic [ALUOP_W-1:0] OP_OR   = ALUOP_W'(8'h25);
    localparam logic [ALUOP_W-1:0] OP_XOR  = ALUOP_W'(8'h26);
    localparam logic [ALUOP_W-1:0] OP_NOR  = ALUOP_W'(8'h27);
    localparam logic [ALUOP_W-1:0] OP_SLL  = ALUOP_W'(8'h7C);
    localparam logic [ALUOP_W-1:0] OP_SRL  = ALUOP_W'(8'h02);
    localparam logic [ALUOP_W-1:0] OP_SRA  = ALUOP_W'(8'h03);
    localparam logic [ALUOP_W-1:0] OP_ADD  = ALUOP_W'(8'h20);
    localparam logic [ALUOP_W-1:0] OP_ADDU = ALUOP_W'(8'h21);
    localparam logic [ALUOP_W-1:0] OP_SUB  = ALUOP_W'(8'h22);
    localparam logic [ALUOP_W-1:0] OP_SUBU = ALUOP_W'(8'h23);
    localparam logic [ALUOP_W-1:0] OP_SLT  = ALUOP_W'(8'h2A);
    localparam logic [ALUOP_W-1:0] OP_SLTU = ALUOP_W'(8'h2B);
    localparam logic [ALUOP_W-1:0] OP_DIV  = ALUOP_W'(8'h1A);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    logic [DATA_W-1:0] a, b, sum, dif, alu_res;
    logic [SH_W-1:0]   shamt;
    logic              ovf, is_div;

    assign a      = reg_rd_data1_in;
    assign b      = reg_rd_data2_in;
    assign shamt  = a[SH_W-1:0];
    assign sum    = a + b;
    assign dif    = a - b;
    assign is_div = (alusel_in == SEL_DIV);

    always_comb begin
        alu_res = '0;
        ovf     = 1'b0;
        case (alusel_in)
            SEL_LOGIC: case (aluop_in)
                OP_AND:  alu_res = a & b;
                OP_OR:   alu_res = a | b;
                OP_XOR:  alu_res = a ^ b;
                OP_NOR:  alu_res = ~(a | b);
                default: alu_res = '0;
            endcase
            SEL_SHIFT: case (aluop_in)
                OP_SLL:  alu_res = b << shamt;
                OP_SRL:  alu_res = b >> shamt;
                OP_SRA:  alu_res = $unsigned($signed(b) >>> shamt);
                default: alu_res = '0;
            endcase
            SEL_ARITH: case (aluop_in)
                OP_ADD: begin
                    alu_res = sum;
                    ovf     = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
                end
                OP_ADDU: alu_res = sum;
                OP_SUB: begin
                    alu_res = dif;
                    ovf     = (a[MSB] != b[MSB]) && (dif[MSB] != a[MSB]);
                end
                OP_SUBU: alu_res = dif;
                OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, $signed(a) < $signed(b)};
                OP_SLTU: alu_res = {{(DATA_W-1){1'b0}}, a < b};
                default: alu_res = '0;
            endcase
            default: alu_res = '0;
        endcase
    end

    assign reg_wr_addr_out = reg_wr_addr_in;
    assign reg_wr_data_out = alu_res;
    assign reg_wr_en_out   = reg_wr_en_in && !ovf && !is_div;
    assign ovf_exc_out     = ovf;

    // ---------------- divider ----------------
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] rem_q, rem_d, quo_q, quo_d, dsr_q, dsr_d, hi_q, hi_d, lo_q, lo_d;
    logic              qneg_q, qneg_d, rneg_q, rneg_d, dz_q, dz_d;

    logic              div_signed, a_neg, b_neg, ge;
    logic [DATA_W-1:0] a_abs, b_abs, shl, q_fix, r_fix;
    logic [DATA_W:0]   trial;

    assign div_signed = (aluop_in == OP_DIV);
    assign a_neg      = div_signed && a[MSB];
    assign b_neg      = div_signed && b[MSB];
    assign a_abs      = a_neg ? -a : a;
    assign b_abs      = b_neg ? -b : b;

    // One restoring step: bring in the next dividend bit, keep the trial
    // difference only if it did not borrow.
    assign shl   = {rem_q[DATA_W-2:0], quo_q[MSB]};
    assign trial = {rem_q, quo_q[MSB]} - {1'b0, dsr_q};
    assign ge    = !trial[DATA_W];

    // Divide-by-zero keeps the all-ones quotient; the remainder path
    // re-applies the dividend sign, which restores the raw dividend.
    assign q_fix = (qneg_q && !dz_q) ? -quo_q : quo_q;
    assign r_fix = rneg_q ? -rem_q : rem_q;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        rem_d          = rem_q;
        quo_d          = quo_q;
        dsr_d          = dsr_q;
        qneg_d         = qneg_q;
        rneg_d         = rneg_q;
        dz_d           = dz_q;
        hi_d           = hi_q;
        lo_d           = lo_q;
        stall_req_out  = 1'b0;
        hilo_wr_en_out = 1'b0;
        case (state_q)
            S_IDLE: if (is_div) begin
                stall_req_out = 1'b1;
                dsr_d  = b_abs;
                qneg_d = a_neg ^ b_neg;
                rneg_d = a_neg;
                cnt_d  = '0;
                if (b_abs == '0) begin
                    rem_d   = a_abs;
                    quo_d   = '1;
                    dz_d    = 1'b1;
                    state_d = S_DONE;
                end else begin
                    rem_d   = '0;
                    quo_d   = a_abs;
                    dz_d    = 1'b0;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                stall_req_out = 1'b1;
                rem_d = ge ? trial[DATA_W-1:0] : shl;
                quo_d = {quo_q[DATA_W-2:0], ge};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_MAX) state_d = S_DONE;
            end
            S_DONE: begin
                hilo_wr_en_out = 1'b1;
                hi_d    = r_fix;
                lo_d    = q_fix;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (flush) begin
            state_d        = S_IDLE;
            stall_req_out  = 1'b0;
            hilo_wr_en_out = 1'b0;
            hi_d           = hi_q;
            lo_d           = lo_q;
        end
        if (rst) begin
            stall_req_out  = 1'b0;
            hilo_wr_en_out = 1'b0;
        end
    end

    assign hi_out = rst ? '0 : (hilo_wr_en_out ? r_fix : hi_q);
    assign lo_out = rst ? '0 : (hilo_wr_en_out ? q_fix : lo_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dsr_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dsr_q   <= dsr_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end
endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: stimulus pushes expectations, a negedge
// monitor pops and compares combinational results, HI/LO strobes and stall lengths.
module tb_ex_stage;
    localparam logic [2:0] NOP = 3'd0, LOG = 3'd1, SHF = 3'd2, ARI = 3'd4, DVS = 3'd5;
    localparam logic [7:0] AND_ = 8'h24, OR_ = 8'h25, XOR_ = 8'h26, NOR_ = 8'h27;
    localparam logic [7:0] SLL = 8'h7C, SRL = 8'h02, SRA = 8'h03;
    localparam logic [7:0] ADD = 8'h20, ADDU = 8'h21, SUB = 8'h22, SUBU = 8'h23;
    localparam logic [7:0] SLT = 8'h2A, SLTU = 8'h2B, DIV = 8'h1A, DIVU = 8'h1B;

    logic        clk, rst, flush, wen, cmb_vld;
    logic [31:0] d1, d2;
    logic [4:0]  waddr;
    logic [2:0]  alusel;
    logic [7:0]  aluop;
    logic [4:0]  waddr_o;
    logic        wen_o, hilo_we, ovf_o, stall_o;
    logic [31:0] wdata_o, hi_o, lo_o;

    int compared = 0;
    int mismatched = 0;

    typedef struct {
        string       nm;
        logic [31:0] data;
        logic        wen;
        logic        ovf;
        logic        stall;
        logic [4:0]  addr;
        logic        chk_hl;
        logic [31:0] hi;
        logic [31:0] lo;
    } cmb_t;
    typedef struct {
        string       nm;
        logic [31:0] hi;
        logic [31:0] lo;
    } hl_t;

    cmb_t cq[$];
    hl_t  hq[$];
    int   sq[$];

    ex_stage dut (
        .clk(clk), .rst(rst), .flush(flush),
        .reg_rd_data1_in(d1), .reg_rd_data2_in(d2),
        .reg_wr_addr_in(waddr), .reg_wr_en_in(wen),
        .alusel_in(alusel), .aluop_in(aluop),
        .reg_wr_addr_out(waddr_o), .reg_wr_en_out(wen_o),
        .reg_wr_data_out(wdata_o), .hilo_wr_en_out(hilo_we),
        .hi_out(hi_o), .lo_out(lo_o),
        .ovf_exc_out(ovf_o), .stall_req_out(stall_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Monitor
    initial begin
        cmb_t c;
        hl_t  h;
        int   run;
        run = 0;
        forever begin
            @(negedge clk);
            if (cmb_vld) begin
                compared++;
                if (cq.size() == 0) begin
                    mismatched++;
                    $display("FAIL cmb_underflow: no expectation queued");
                end else begin
                    c = cq.pop_front();
                    if (wdata_o !== c.data || wen_o !== c.wen || ovf_o !== c.ovf ||
                        stall_o !== c.stall || waddr_o !== c.addr ||
                        (c.chk_hl && (hi_o !== c.hi || lo_o !== c.lo))) begin
                        mismatched++;
                        $display("FAIL %s: got data=%h wen=%b ovf=%b stall=%b addr=%h hi=%h lo=%h; want data=%h wen=%b ovf=%b stall=%b addr=%h hi=%h lo=%h (hilo checked=%b)",
                                 c.nm, wdata_o, wen_o, ovf_o, stall_o, waddr_o, hi_o, lo_o,
                                 c.data, c.wen, c.ovf, c.stall, c.addr, c.hi, c.lo, c.chk_hl);
                    end
                end
            end
            if (hilo_we === 1'b1) begin
                compared++;
                if (hq.size() == 0) begin
                    mismatched++;
                    $display("FAIL unexpected_hilo_strobe: got hi=%h lo=%h, want no strobe", hi_o, lo_o);
                end else begin
                    h = hq.pop_front();
                    if (hi_o !== h.hi || lo_o !== h.lo) begin
                        mismatched++;
                        $display("FAIL %s: got hi=%h lo=%h, want hi=%h lo=%h", h.nm, hi_o, lo_o, h.hi, h.lo);
                    end
                end
            end
            if (stall_o === 1'b1) run++;
            else if (run != 0) begin
                compared++;
                if (sq.size() == 0) begin
                    mismatched++;
                    $display("FAIL unexpected_stall: got %0d cycles, want none", run);
                end else if (sq[0] != run) begin
                    mismatched++;
                    $display("FAIL stall_len: got %0d cycles, want %0d", run, sq[0]);
                    void'(sq.pop_front());
                end else void'(sq.pop_front());
                run = 0;
            end
        end
    end

    task automatic drive(input logic [2:0] s, input logic [7:0] op,
                         input logic [31:0] a, input logic [31:0] b, input logic we);
        alusel = s; aluop = op; d1 = a; d2 = b; wen = we;
        waddr  = waddr + 5'd1;
    endtask

    task automatic cmb(input string nm, input logic [2:0] s, input logic [7:0] op,
                       input logic [31:0] a, input logic [31:0] b, input logic we,
                       input logic [31:0] ed, input logic ew, input logic eo,
                       input logic chk, input logic [31:0] eh, input logic [31:0] el);
        @(posedge clk); #1;
        drive(s, op, a, b, we);
        cq.push_back('{nm, ed, ew, eo, 1'b0, waddr, chk, eh, el});
        cmb_vld = 1'b1;
        @(posedge clk); #1;
        cmb_vld = 1'b0;
        drive(NOP, 8'h00, 32'h0, 32'h0, 1'b0);
    endtask

    // Issues a divide and checks its first (IDLE) cycle; returns in cycle 1.
    task automatic start_div(input string nm, input logic [7:0] op,
                             input logic [31:0] a, input logic [31:0] b);
        @(posedge clk); #1;
        drive(DVS, op, a, b, 1'b1);
        cq.push_back('{{nm, "_issue"}, 32'h0, 1'b0, 1'b0, 1'b1, waddr, 1'b0, 32'h0, 32'h0});
        cmb_vld = 1'b1;
        @(posedge clk); #1;
        cmb_vld = 1'b0;
    endtask

    // Holds the divide on the inputs until stall drops (DONE cycle).
    task automatic run_div(input string nm, input logic [7:0] op,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] eh, input logic [31:0] el, input int est);
        bit seen;
        seen = 1'b0;
        hq.push_back('{nm, eh, el});
        sq.push_back(est);
        start_div(nm, op, a, b);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (stall_o !== 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            compared++;
            mismatched++;
            $display("FAIL %s_timeout: stall still high after 50 cycles, want drop", nm);
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; cmb_vld = 1'b0; waddr = 5'd0;
        drive(NOP, 8'h00, 32'h0, 32'h0, 1'b0);

        // Reset: divider quiet, combinational path live
        cmb("rst_div",  DVS, DIV,  32'd7, 32'd2, 1'b1, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
        cmb("rst_addu", ARI, ADDU, 32'd1, 32'd2, 1'b1, 32'h3, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        cmb("or",   LOG, OR_,  32'h0F0F, 32'h00FF, 1'b1, 32'h0FFF, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        cmb("and",  LOG, AND_, 32'hF0F0F0F0, 32'hFF00FF00, 1'b1, 32'hF000F000, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        cmb("xor",  LOG, XOR_, 32'hFFFF0000, 32'h0F0F0F0F, 1'b1, 32'hF0F00F0F, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        cmb("nor",  LOG, NOR_, 32'h0, 32'h0, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        cmb("logic_badop", LOG, 8'h20, 32'h1, 32'h2, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        cmb("sra",  SHF, SRA,  32'd4, 32'h80000000, 1'b1, 32'hF8000000, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        cmb("srl",  SHF, SRL,  32'd4, 32'h80000000, 1'b1, 32'h08000000, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        cmb("sll31", SHF, SLL, 32'd31, 32'h1, 1'b1, 32'h80000000, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        cmb("sll_nowe", SHF, SLL, 32'd1, 32'h3, 1'b0, 32'h6, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        cmb("add_ovf", ARI, ADD, 32'h7FFFFFFF, 32'h1, 1'b1, 32'h80000000, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        cmb("addu",    ARI, ADDU, 32'h7FFFFFFF, 32'h1, 1'b1, 32'h80000000, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        cmb("add_ok",  ARI, ADD, 32'd5, 32'hFFFFFFFD, 1'b1, 32'h2, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        cmb("sub_ovf", ARI, SUB, 32'h80000000, 32'h1, 1'b1, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        cmb("subu",    ARI, SUBU, 32'h0, 32'h1, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        cmb("slt",     ARI, SLT, 32'hFFFFFFFF, 32'h1, 1'b1, 32'h1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        cmb("sltu",    ARI, SLTU, 32'hFFFFFFFF, 32'h1, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        cmb("nop",     NOP, OR_, 32'h1234, 32'h5678, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);

        // Divides
        run_div("div_m7_2",   DIV,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 33);
        run_div("divu_100_7", DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 33);
        cmb("hilo_hold", LOG, OR_, 32'h1, 32'h2, 1'b1, 32'h3, 1'b1, 1'b0, 1'b1, 32'd2, 32'd14);
        run_div("divu_5_0",   DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 1);
        run_div("div_min_m1", DIV,  32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 33);

        // Flush in BUSY cycle 10
        sq.push_back(10);
        start_div("div_flush", DIV, 32'd1000, 32'd3);
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        drive(NOP, 8'h00, 32'h0, 32'h0, 1'b0);
        run_div("divu_9_3", DIVU, 32'd9, 32'd3, 32'd0, 32'd3, 33);

        // Reset in BUSY cycle 20 discards the result
        sq.push_back(20);
        start_div("divu_rst", DIVU, 32'd100, 32'd7);
        repeat (19) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        drive(NOP, 8'h00, 32'h0, 32'h0, 1'b0);
        cmb("after_rst", LOG, AND_, 32'hF, 32'h3, 1'b1, 32'h3, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0);

        // Back-to-back divides
        run_div("div_20_m3", DIV, 32'd20, 32'hFFFFFFFD, 32'd2, 32'hFFFFFFFA, 33);
        run_div("div_m20_3", DIV, 32'hFFFFFFEC, 32'd3, 32'hFFFFFFFE, 32'hFFFFFFFA, 33);
        @(posedge clk); #1;
        drive(NOP, 8'h00, 32'h0, 32'h0, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        compared++;
        if (cq.size() != 0) begin
            mismatched++;
            $display("FAIL cmb_queue_drain: got %0d left, want 0", cq.size());
        end
        compared++;
        if (hq.size() != 0) begin
            mismatched++;
            $display("FAIL hilo_queue_drain: got %0d strobes missing, want 0", hq.size());
        end
        compared++;
        if (sq.size() != 0) begin
            mismatched++;
            $display("FAIL stall_queue_drain: got %0d stall runs missing, want 0", sq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
